// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Contents: FSM state encoding (IDLE/RUN/DONE), default operand width.
// Imported by serial_subtractor; no logic of its own.
package serial_sub_pkg;

   localparam int SERIAL_SUB_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// fs_cell: one-bit full subtractor, purely combinational.
// Ports: a (minuend bit), b (subtrahend bit), bi (borrow in) -> d (difference), bo (borrow out).
// Latency: zero cycles; no flow control.
module fs_cell (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = a ^ b ^ bi;
   // Borrow when the minuend bit is 0 against a 1, or the bits are equal and a borrow is pending.
   assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes a - b - bin one bit per cycle, LSB first, using a single fs_cell.
// Ports: clk, rst (async, active high); start/a/b/bin request; busy, done, diff, bout result;
//        ovf (signed overflow) exists only when SERIAL_SUB_OVF_EN is defined.
// Latency: start accepted on edge t -> busy for WIDTH cycles, done pulses in the cycle after edge t+WIDTH+1.
// Backpressure: none; start is only honoured in IDLE or DONE and silently ignored while busy.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = SERIAL_SUB_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             bout
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t state;
   state_t state_nxt;

   // a_sh doubles as the result register: each processed minuend bit leaves at the LSB
   // and the matching difference bit enters at the MSB, so after WIDTH shifts it holds the result.
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             br;
   logic [CW-1:0]    cnt;

   logic accept;
   logic last_bit;
   logic cell_d;
   logic cell_bo;

`ifdef SERIAL_SUB_OVF_EN
   // Operand sign bits are shifted out during RUN, so keep a copy for the overflow test.
   logic a_msb;
   logic b_msb;
`endif

   assign accept   = start && (state != RUN);
   assign last_bit = (state == RUN) && (cnt == LAST_BIT);

   fs_cell u_fs_cell (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .bi (br),
      .d  (cell_d),
      .bo (cell_bo)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (cnt == LAST_BIT) state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = (state == RUN);
   end

   // done is registered off the DONE state, so the result is already stable a cycle before the pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done <= 1'b0;
      end else begin
         done <= (state == DONE);
      end
   end

   // Serial datapath and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh  <= '0;
         b_sh  <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         diff  <= '0;
         bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf   <= 1'b0;
`endif
      end else if (accept) begin
         a_sh  <= a;
         b_sh  <= b;
         br    <= bin;
         cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
`endif
      end else if (state == RUN) begin
         a_sh <= {cell_d, a_sh[WIDTH-1:1]};
         b_sh <= b_sh >> 1;
         br   <= cell_bo;
         cnt  <= cnt + CW'(1);
         if (last_bit) begin
            diff <= {cell_d, a_sh[WIDTH-1:1]};
            bout <= cell_bo;
`ifdef SERIAL_SUB_OVF_EN
            // The last processed difference bit is the result's sign bit.
            ovf  <= (a_msb != b_msb) && (cell_d != a_msb);
`endif
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH=8); honours SERIAL_SUB_OVF_EN when defined.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk   = 1'b0;
   logic         rst   = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         bin   = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
      .ovf   (ovf),
`endif
      .bout  (bout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   last_acc = 0;
   bit   have_acc = 1'b0;
   bit   running  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic exp_t model(input int av, input int bv, input int bi, input int dc);
      exp_t e;
      int   full;
      int   sa;
      int   sbv;
      int   s;
      full   = av - bv - bi;
      e.diff = W'(full);
      e.bout = (av < bv + bi);
      sa     = (av >= (1 << (W - 1))) ? av - (1 << W) : av;
      sbv    = (bv >= (1 << (W - 1))) ? bv - (1 << W) : bv;
      s      = sa - sbv - bi;
      e.ovf  = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
      e.cyc  = dc;
      return e;
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Waits until a start would be accepted, optionally toggling start/operands while busy,
   // then presents the request for exactly one accepting edge.
   task automatic issue(input int av, input int bv, input int bi, input bit noise);
      while (have_acc && (cyc + 1 < last_acc + W + 1)) begin
         if (noise) begin
            start = 1'($urandom_range(0, 1));
            a     = W'($urandom_range(0, (1 << W) - 1));
            b     = W'($urandom_range(0, (1 << W) - 1));
            bin   = 1'($urandom_range(0, 1));
         end
         step();
      end
      start    = 1'b1;
      a        = W'(av);
      b        = W'(bv);
      bin      = 1'(bi);
      last_acc = cyc + 1;
      have_acc = 1'b1;
      sb.push_back(model(av, bv, bi, last_acc + W + 1));
      step();
      start = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_diff"}, diff, 0);
      chk({tag, "_bout"}, bout, 0);
`ifdef SERIAL_SUB_OVF_EN
      chk({tag, "_ovf"}, ovf, 0);
`endif
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (running && !rst) begin
         chk("busy", busy, (have_acc && cyc >= last_acc && cyc <= last_acc + W - 1));
         if (done) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_done at cycle %0d: got done=1, expected done=0", cyc);
            end else begin
               e = sb.pop_front();
               chk("done_cycle", cyc, e.cyc);
               chk("diff", diff, e.diff);
               chk("bout", bout, e.bout);
`ifdef SERIAL_SUB_OVF_EN
               chk("ovf", ovf, e.ovf);
`endif
            end
         end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL missing_done at cycle %0d: got done=0, expected done=1 at cycle %0d", cyc, sb[0].cyc);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (2) step();
      check_reset_outputs("reset");

      // Release reset and request in the same cycle: the next edge must accept.
      rst     = 1'b0;
      running = 1'b1;
      issue('h35, 'h12, 0, 1'b0);
      issue('h00, 'h01, 0, 1'b0);
      issue('h00, 'h00, 1, 1'b0);
      issue('h80, 'h01, 0, 1'b0);
      issue('h10, 'h01, 0, 1'b0);
      issue('h5A, 'h5A, 0, 1'b0);
      issue('h7F, 'hFF, 0, 1'b0);
      issue('hFF, 'hFF, 1, 1'b0);

      // A start pulse three cycles into RUN must not disturb the operation.
      issue('h44, 'h21, 0, 1'b0);
      step();
      step();
      start = 1'b1;
      a     = 'h99;
      b     = 'h11;
      bin   = 1'b1;
      step();
      start = 1'b0;

      // start held high through DONE: second request is taken back-to-back.
      issue('hFF, 'h0F, 0, 1'b0);
      start = 1'b1;
      a     = 'h10;
      b     = 'h20;
      bin   = 1'b0;
      issue('h10, 'h20, 0, 1'b0);

      // Reset in the fourth RUN cycle aborts the operation without a done pulse.
      issue('h77, 'h33, 1, 1'b0);
      repeat (3) step();
      rst      = 1'b1;
      void'(sb.pop_back());
      have_acc = 1'b0;
      #1;
      check_reset_outputs("abort");
      step();
      check_reset_outputs("abort_hold");
      step();
      rst = 1'b0;
      issue('h63, 'h2A, 1, 1'b0);

      for (int i = 0; i < 30; i++) begin
         int gap;
         gap = $urandom_range(0, W + 3);
         repeat (gap) step();
         issue($urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1),
               $urandom_range(0, 1), 1'b1);
      end

      start = 1'b0;
      for (int i = 0; i < 3 * W && sb.size() > 0; i++) step();
      chk("drain_pending", sb.size(), 0);
      repeat (W) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
